// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg
// Shared definitions for the approximate multiplier pipeline:
//   - mode_e      : per-operand multiplication mode encoding
//   - MAX_PW      : widest product the helper functions handle (W <= 32)
//   - col_mask()  : keeps product columns at or above a truncation depth
//   - sat_add()   : unsigned add that clips at 2^width - 1
package approx_mult_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_TRUNC = 2'd1,
        MODE_COMP  = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    localparam int MAX_PW = 64;

    // Bit i is set when column i survives truncation (i >= l).
    function automatic logic [MAX_PW-1:0] col_mask(input int l);
        logic [MAX_PW-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_PW; i++) begin
            m[i] = (i >= l);
        end
        return m;
    endfunction

    // Sum of a and b clipped to the largest value representable in
    // 'width' bits; the 65-bit intermediate keeps the carry visible.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int          width);
        logic [64:0] s;
        logic [64:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << width) - 65'd1;
        return (s > lim) ? lim[63:0] : s[63:0];
    endfunction

endpackage

// File: rtl/approx_mult_pipe_err_monitor.sv
// approx_err_monitor
// Accumulates error statistics of the selected-mode product against the
// exact product for every result handed to the consumer.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clr             : clear all statistics (wins over a coinciding sample)
//   xfer            : an output transfer happens this cycle
//   z, z_exact      : selected-mode and exact products of that transfer
//   cnt             : number of samples since clear, saturating
//   sum             : sum of absolute errors, saturating
//   max             : largest absolute error seen
module approx_err_monitor
    import approx_mult_pkg::*;
#(
    parameter int PW    = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             xfer,
    input  logic [PW-1:0]    z,
    input  logic [PW-1:0]    z_exact,
    output logic [ACC_W-1:0] cnt,
    output logic [ACC_W-1:0] sum,
    output logic [PW-1:0]    max
);

    logic [PW-1:0]    abs_err;
    logic [ACC_W-1:0] cnt_next;
    logic [ACC_W-1:0] sum_next;

    // |z_exact - z| without needing the sign bit of a wider difference:
    // both operands are unsigned, so subtracting the smaller from the
    // larger always fits in PW bits.
    always_comb begin
        abs_err  = (z_exact >= z) ? (z_exact - z) : (z - z_exact);
        cnt_next = ACC_W'(sat_add(64'(cnt), 64'd1, ACC_W));
        sum_next = ACC_W'(sat_add(64'(sum), 64'(abs_err), ACC_W));
    end

    // Clear has priority over a sample arriving in the same cycle, so
    // that sample is simply not counted.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            sum <= '0;
            max <= '0;
        end else if (xfer) begin
            cnt <= cnt_next;
            sum <= sum_next;
            if (abs_err > max) begin
                max <= abs_err;
            end
        end
    end

endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe
// Three-stage pipelined unsigned W x W multiplier with a per-operand mode:
// exact, column-truncated (columns below L dropped) or truncated plus a
// 2^(L-1) compensation constant. The exact product is always produced
// alongside, and an error monitor keeps statistics on delivered results.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : operand handshake
//   x, y, mode             : operands and mode (3 behaves as exact)
//   out_valid/out_ready    : result handshake
//   z, z_exact             : selected-mode product, exact product
//   stat_clr               : clear statistics
//   stat_cnt/sum/max       : delivered count, error sum, max error
module approx_mult_pipe #(
    parameter int W     = 8,
    parameter int L     = 6,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   z,
    output logic [2*W-1:0]   z_exact,
    input  logic             stat_clr,
    output logic [ACC_W-1:0] stat_cnt,
    output logic [ACC_W-1:0] stat_sum,
    output logic [2*W-1:0]   stat_max
);

    import approx_mult_pkg::*;

    localparam int PW = 2 * W;
    localparam int H  = W / 2;

    localparam logic [PW-1:0] MASK      = PW'(col_mask(L));
    localparam logic [PW-1:0] COMP_BIAS =
        (L > 0) ? (PW'(1) << ((L > 0) ? (L - 1) : 0)) : '0;

    // Stage registers
    logic          s1_valid;
    logic [W-1:0]  s1_x;
    logic [W-1:0]  s1_y;
    logic [1:0]    s1_mode;

    logic          s2_valid;
    logic [PW-1:0] s2_lo_exact;
    logic [PW-1:0] s2_hi_exact;
    logic [PW-1:0] s2_lo_trunc;
    logic [PW-1:0] s2_hi_trunc;
    logic [1:0]    s2_mode;

    logic          s3_valid;
    logic [PW-1:0] s3_z;
    logic [PW-1:0] s3_z_exact;

    logic adv1;
    logic adv2;
    logic adv3;

    // A stage may load when it is empty or its content moves on. Only
    // adv3 looks at out_ready, so out_valid stays a pure register output.
    assign adv3     = ~s3_valid | out_ready;
    assign adv2     = ~s2_valid | adv3;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = ~rst & adv1;

    assign out_valid = s3_valid;
    assign z         = s3_z;
    assign z_exact   = s3_z_exact;

    // Stage 1: capture operands and their mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_mode  <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            s1_x     <= x;
            s1_y     <= y;
            s1_mode  <= mode;
        end
    end

    // Partial-product rows: row j is x shifted by j when y[j] is set.
    // The truncated row keeps only columns at or above L.
    logic [PW-1:0] row_exact [W];
    logic [PW-1:0] row_trunc [W];

    for (genvar j = 0; j < W; j++) begin : g_rows
        assign row_exact[j] = s1_y[j] ? (PW'(s1_x) << j) : '0;
        assign row_trunc[j] = row_exact[j] & MASK;
    end

    logic [PW-1:0] lo_exact;
    logic [PW-1:0] hi_exact;
    logic [PW-1:0] lo_trunc;
    logic [PW-1:0] hi_trunc;

    // Split the rows into a lower and an upper half so each stage only
    // carries half of the adder tree.
    always_comb begin
        lo_exact = '0;
        hi_exact = '0;
        lo_trunc = '0;
        hi_trunc = '0;
        for (int j = 0; j < W; j++) begin
            if (j < H) begin
                lo_exact = lo_exact + row_exact[j];
                lo_trunc = lo_trunc + row_trunc[j];
            end else begin
                hi_exact = hi_exact + row_exact[j];
                hi_trunc = hi_trunc + row_trunc[j];
            end
        end
    end

    // Stage 2: half-row partial sums, exact and masked.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            s2_lo_exact <= '0;
            s2_hi_exact <= '0;
            s2_lo_trunc <= '0;
            s2_hi_trunc <= '0;
            s2_mode     <= '0;
        end else if (adv2) begin
            s2_valid    <= s1_valid;
            s2_lo_exact <= lo_exact;
            s2_hi_exact <= hi_exact;
            s2_lo_trunc <= lo_trunc;
            s2_hi_trunc <= hi_trunc;
            s2_mode     <= s1_mode;
        end
    end

    logic [PW-1:0] sum_exact;
    logic [PW-1:0] sum_trunc;
    logic [PW-1:0] z_sel;

    // Final adds and mode selection; the reserved encoding falls back
    // to the exact product. The compensated sum wraps modulo 2^PW.
    always_comb begin
        sum_exact = s2_lo_exact + s2_hi_exact;
        sum_trunc = s2_lo_trunc + s2_hi_trunc;
        case (mode_e'(s2_mode))
            MODE_TRUNC: z_sel = sum_trunc;
            MODE_COMP:  z_sel = sum_trunc + COMP_BIAS;
            default:    z_sel = sum_exact;
        endcase
    end

    // Stage 3: output register, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid   <= 1'b0;
            s3_z       <= '0;
            s3_z_exact <= '0;
        end else if (adv3) begin
            s3_valid   <= s2_valid;
            s3_z       <= z_sel;
            s3_z_exact <= sum_exact;
        end
    end

    approx_err_monitor #(
        .PW    (PW),
        .ACC_W (ACC_W)
    ) u_err_monitor (
        .clk     (clk),
        .rst     (rst),
        .clr     (stat_clr),
        .xfer    (s3_valid & out_ready),
        .z       (s3_z),
        .z_exact (s3_z_exact),
        .cnt     (stat_cnt),
        .sum     (stat_sum),
        .max     (stat_max)
    );

endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe
// Scoreboard bench for approx_mult_pipe (W=8, L=6). Stimulus pushes the
// hand-computed products when an operand is accepted; a monitor pops and
// compares on every output transfer. A second instance with ACC_W=4 shares
// all inputs so saturation of the statistics can be observed.
module tb_approx_mult_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        stat_clr = 1'b0;
    logic [7:0]  x = '0;
    logic [7:0]  y = '0;
    logic [1:0]  mode = '0;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] z;
    logic [15:0] z_exact;
    logic [31:0] stat_cnt;
    logic [31:0] stat_sum;
    logic [15:0] stat_max;

    logic        in_ready_s;
    logic        out_valid_s;
    logic [15:0] z_s;
    logic [15:0] z_exact_s;
    logic [3:0]  stat_cnt_s;
    logic [3:0]  stat_sum_s;
    logic [15:0] stat_max_s;

    approx_mult_pipe #(.W(8), .L(6), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .z(z), .z_exact(z_exact),
        .stat_clr(stat_clr), .stat_cnt(stat_cnt), .stat_sum(stat_sum),
        .stat_max(stat_max)
    );

    approx_mult_pipe #(.W(8), .L(6), .ACC_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .x(x), .y(y), .mode(mode), .out_valid(out_valid_s),
        .out_ready(out_ready), .z(z_s), .z_exact(z_exact_s),
        .stat_clr(stat_clr), .stat_cnt(stat_cnt_s), .stat_sum(stat_sum_s),
        .stat_max(stat_max_s)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic [15:0] z;
        logic [15:0] ze;
    } exp_t;

    exp_t sb[$];
    bit   rand_done = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Offers one operand pair starting just after a rising edge and
    // returns just after the edge that accepted it.
    task automatic applyStimulus(input logic [7:0] ax, input logic [7:0] ay,
                                 input logic [1:0] am, input logic [15:0] ez,
                                 input logic [15:0] eex, input bit track);
        bit accepted;
        bit rdy;
        accepted = 1'b0;
        x = ax;
        y = ay;
        mode = am;
        in_valid = 1'b1;
        for (int i = 0; i < 500 && !accepted; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) accepted = 1'b1;
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 64'(accepted), 64'd1);
        else if (track) sb.push_back('{z: ez, ze: eex});
    endtask

    task automatic waitDrain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) checkOutput(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic clearStats();
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
    endtask

    // Monitor: compares every result handed to the consumer in order.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 64'(out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("z", 64'(z), 64'(e.z));
                    checkOutput("z_exact", 64'(z_exact), 64'(e.ze));
                end
            end
        end
    end

    initial begin
        logic [7:0] rx;
        logic [7:0] ry;

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("in_ready_in_reset", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_reset", 64'(in_ready), 64'd1);
        checkOutput("out_valid_reset", 64'(out_valid), 64'd0);
        checkOutput("z_reset", 64'(z), 64'd0);
        checkOutput("z_exact_reset", 64'(z_exact), 64'd0);
        checkOutput("stat_cnt_reset", 64'(stat_cnt), 64'd0);
        checkOutput("stat_sum_reset", 64'(stat_sum), 64'd0);
        checkOutput("stat_max_reset", 64'(stat_max), 64'd0);
        align();

        // Truncated 255 x 255: dropped columns 0..5 weigh 321
        applyStimulus(8'd255, 8'd255, 2'd1, 16'd64704, 16'd65025, 1'b1);
        waitDrain("drain_trunc");
        checkOutput("trunc_cnt", 64'(stat_cnt), 64'd1);
        checkOutput("trunc_sum", 64'(stat_sum), 64'd321);
        checkOutput("trunc_max", 64'(stat_max), 64'd321);
        checkOutput("sat_sum_acc4", 64'(stat_sum_s), 64'd15);
        checkOutput("sat_cnt_acc4", 64'(stat_cnt_s), 64'd1);
        align();

        // Compensated mode, then the reserved encoding acting as exact
        clearStats();
        @(negedge clk);
        checkOutput("cnt_after_clear", 64'(stat_cnt), 64'd0);
        checkOutput("max_after_clear", 64'(stat_max), 64'd0);
        align();
        applyStimulus(8'd255, 8'd255, 2'd2, 16'd64736, 16'd65025, 1'b1);
        applyStimulus(8'd3,   8'd5,   2'd2, 16'd32,    16'd15,    1'b1);
        applyStimulus(8'd12,  8'd13,  2'd3, 16'd156,   16'd156,   1'b1);
        waitDrain("drain_comp");
        checkOutput("comp_cnt", 64'(stat_cnt), 64'd3);
        checkOutput("comp_sum", 64'(stat_sum), 64'd306);
        checkOutput("comp_max", 64'(stat_max), 64'd289);
        align();

        // Back-pressure: three results fill the pipe, then hold
        out_ready = 1'b0;
        applyStimulus(8'd10,  8'd20, 2'd0, 16'd200, 16'd200, 1'b1);
        applyStimulus(8'd7,   8'd9,  2'd0, 16'd63,  16'd63,  1'b1);
        applyStimulus(8'd255, 8'd1,  2'd0, 16'd255, 16'd255, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
            checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_z", 64'(z), 64'd200);
            checkOutput("stall_z_exact", 64'(z_exact), 64'd200);
        end
        align();
        // Release together with a clear: the first transfer is discarded
        out_ready = 1'b1;
        stat_clr = 1'b1;
        @(negedge clk);
        checkOutput("release_valid0", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        @(negedge clk);
        checkOutput("release_valid1", 64'(out_valid), 64'd1);
        checkOutput("clr_wins_cnt", 64'(stat_cnt), 64'd0);
        checkOutput("clr_wins_sum", 64'(stat_sum), 64'd0);
        @(negedge clk);
        checkOutput("release_valid2", 64'(out_valid), 64'd1);
        waitDrain("drain_stall");
        checkOutput("post_clr_cnt", 64'(stat_cnt), 64'd2);
        align();

        // Exact streaming with random back-pressure
        clearStats();
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    rx = 8'($urandom_range(0, 255));
                    ry = 8'($urandom_range(0, 255));
                    applyStimulus(rx, ry, 2'd0, 16'(rx) * 16'(ry),
                                  16'(rx) * 16'(ry), 1'b1);
                    if ($urandom_range(0, 3) == 0) align();
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        waitDrain("drain_stream");
        checkOutput("stream_cnt", 64'(stat_cnt), 64'd100);
        checkOutput("stream_sum", 64'(stat_sum), 64'd0);
        checkOutput("stream_max", 64'(stat_max), 64'd0);
        checkOutput("stream_cnt_sat", 64'(stat_cnt_s), 64'd15);
        align();

        // Reset with three results in flight
        out_ready = 1'b0;
        applyStimulus(8'd100, 8'd100, 2'd1, 16'd0, 16'd0, 1'b0);
        applyStimulus(8'd50,  8'd60,  2'd2, 16'd0, 16'd0, 1'b0);
        applyStimulus(8'd9,   8'd9,   2'd0, 16'd0, 16'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_z", 64'(z), 64'd0);
        checkOutput("rst_stat_cnt", 64'(stat_cnt), 64'd0);
        checkOutput("rst_stat_sum", 64'(stat_sum), 64'd0);
        align();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("no_stale_valid", 64'(out_valid), 64'd0);
        checkOutput("no_stale_cnt", 64'(stat_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/approx_mult_pipe.md
# approx_mult_pipe

Parametrised, pipelined unsigned W×W multiplier with run-time selectable exact/approximate mode and a built-in error monitor. Generalises the fixed 8×8, l=6 column-truncated multipliers to any width and truncation depth, adds a valid/ready stream interface, and accumulates error statistics against the exact product in hardware, so approximate configurations are characterised on-chip rather than only offline.

## Interface
- W, 8, operand width (≥2)
- L, 6, number of low product columns subject to approximation (0 ≤ L < 2W)
- ACC_W, 32, width of error-sum and sample-count registers
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block accepts operands this cycle
- x  input  W  multiplicand
- y  input  W  multiplier
- mode  input  2  0 EXACT, 1 TRUNC, 2 COMP, 3 reserved (behaves as EXACT); sampled with operands
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- z  output  2W  selected-mode product
- z_exact  output  2W  exact product of same operands
- stat_clr  input  1  clears statistics
- stat_cnt  output  ACC_W  results delivered since clear
- stat_sum  output  ACC_W  sum of |z_exact − z|, saturating
- stat_max  output  2W  maximum |z_exact − z|

## Operation
- Partial products pp[i][j] = x[i] & y[j], weight 2^(i+j).
- EXACT: z = x·y.
- TRUNC: z = Σ pp[i][j]·2^(i+j) over i+j ≥ L (columns below L dropped).
- COMP: TRUNC + 2^(L−1) when L > 0; equal to TRUNC when L = 0. Sum taken mod 2^(2W).
- z_exact always x·y regardless of mode.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Statistics update on each output transfer: cnt += 1, sum += |err|, max = max(max, |err|), err = z_exact − z computed in 2W+1 signed bits. cnt and sum saturate at 2^ACC_W − 1; no wrap.
- stat_clr: all three registers to 0 next cycle; if an output transfer coincides, clear wins and that sample is discarded.
- Changing mode between operands never flushes the pipe or statistics; each result carries its own mode.

## Timing
- 3-stage pipeline: S1 registers x, y, mode; S2 registers two half-row partial sums (rows 0..W/2−1 and W/2..W−1, exact and masked versions); S3 registers final z, z_exact.
- Latency: operand accepted at cycle t → out_valid with that result at t+3 when no stall.
- Throughput 1 result/cycle while out_ready held high.
- Back-pressure: stage advances when it is empty or the next stage advances; in_ready = ~S1_valid | S1 advances. Full pipe with out_ready low holds z, z_exact stable and in_ready low.
- out_valid must not depend combinationally on out_ready; in_ready may depend on out_ready.
- Reset: in_ready 0 during rst, 1 from the first cycle after; out_valid 0, z 0, z_exact 0, stat_cnt/sum/max 0. Reset mid-operation drops all in-flight results; no output transfer and no stat update afterwards for them.
- Statistics outputs are registered; they reflect a transfer one cycle after it.

## Structure
- Shared package: mode encoding constants (MODE_EXACT, MODE_TRUNC, MODE_COMP), column-mask function for L, saturating-add helper.
- One sub-module: approx_err_monitor (abs-error, saturating sum/count, max, clear priority), instantiated once at the output.

## Test plan
- W=8, L=6, TRUNC, x=255, y=255 → z=64704, z_exact=65025, stat_sum=321, stat_max=321, stat_cnt=1.
- Same operands, COMP → z=64736; then x=3, y=5 COMP → z=32, z_exact=15; stat_sum=289+17=306, stat_max=289.
- EXACT streaming 100 random pairs with out_ready toggled randomly → results in order, z==z_exact, stat_sum=0, no loss or duplication.
- Fill pipe, hold out_ready=0 for 10 cycles → in_ready 0 after 3 accepts plus S1, outputs stable; release → 1 result/cycle.
- stat_clr asserted on same cycle as an output transfer → all stats read 0 next cycle; ACC_W=4 with 20 transfers → stat_cnt saturates at 15.
- rst asserted with 3 results in flight → out_valid 0 next cycle, stats 0, no stale result after rst deasserts.
